// File: rtl/sb_config_loader.sv
// rtl/sb_config_loader.sv - framed, checksummed byte-stream loader for one switch-box config image
module sb_config_loader #(
    parameter int              CONF_WIDTH = 264,
    parameter int              WORD       = 8,
    parameter logic [WORD-1:0] SYNC       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD-1:0]       in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CONF_WIDTH-1:0] config_out,
    output logic                  config_valid,
    output logic                  done,
    output logic                  error
);
    localparam int N   = (CONF_WIDTH + WORD - 1) / WORD;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int SHW = N * WORD;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {HUNT, LOAD, CSUM, COMMIT} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [WORD-1:0] run_xor;
    logic [SHW-1:0]  shadow;
    logic            xfer;

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            HUNT: begin
                in_ready = 1'b1;
                if (xfer && in_data == SYNC) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (xfer && cnt == LAST) state_next = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                if (xfer) state_next = COMMIT;
            end
            COMMIT: state_next = HUNT;
            default: state_next = HUNT;
        endcase
        // Hold off the upstream while reset is applied, even though state already reads HUNT.
        if (reset) in_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HUNT;
            cnt          <= '0;
            run_xor      <= '0;
            config_out   <= '0;
            config_valid <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                HUNT: begin
                    if (xfer && in_data == SYNC) begin
                        cnt     <= '0;
                        run_xor <= '0;
                        error   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        run_xor <= run_xor ^ in_data;
                        if (cnt != LAST) cnt <= cnt + 1'b1;
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        if (in_data == run_xor) begin
                            config_out   <= shadow[CONF_WIDTH-1:0];
                            config_valid <= 1'b1;
                            done         <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow needs no reset: it only reaches config_out through a checksum-matched commit.
    always_ff @(posedge clk) begin
        if (state == LOAD && xfer) shadow[int'(cnt) * WORD +: WORD] <= in_data;
    end
endmodule
